// File: rtl/aes_req_arbiter.sv
// Round-robin front end that shares one iterative AES-128 core between N_REQ requesters.
// One request is in flight at a time: IDLE grant -> LOAD pulse -> RUN (watchdog) -> RESP handshake.
module aes_req_arbiter #(
    parameter int N_REQ   = 2,
    parameter int MAX_CYC = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid_i,
    output logic [N_REQ-1:0]     req_ready_o,
    input  logic [128*N_REQ-1:0] req_key_i,
    input  logic [128*N_REQ-1:0] req_data_i,
    output logic [N_REQ-1:0]     rsp_valid_o,
    input  logic [N_REQ-1:0]     rsp_ready_i,
    output logic [127:0]         rsp_data_o,
    output logic                 rsp_err_o,
    output logic                 core_load_o,
    output logic [127:0]         core_key_o,
    output logic [127:0]         core_data_o,
    input  logic [127:0]         core_data_i,
    input  logic                 core_done_i,
    output logic                 busy_o
);

    localparam int IDW = (N_REQ > 2) ? 2 : 1;
    localparam int CW  = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [127:0]     key_q, key_d;
    logic [127:0]     pt_q, pt_d;
    logic [127:0]     rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             grant_found;
    logic [IDW-1:0]   grant_id;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input int b);
        int s;
        s = (int'(a) + b) % N_REQ;
        return IDW'(s);
    endfunction

    // Scan downward so the smallest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[wrap_add(rr_ptr_q, i)]) begin
                grant_found = 1'b1;
                grant_id    = wrap_add(rr_ptr_q, i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        pt_d        = pt_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        req_ready_o = '0;
        rsp_valid_o = '0;
        core_load_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Ready is only raised for a valid requester, so a grant is always a handshake.
                if (grant_found) begin
                    req_ready_o[grant_id] = 1'b1;
                    key_d   = req_key_i[int'(grant_id)*128 +: 128];
                    pt_d    = req_data_i[int'(grant_id)*128 +: 128];
                    id_d    = grant_id;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                core_load_o = 1'b1;
                cnt_d       = '0;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (core_done_i) begin
                    rsp_data_d = core_data_i;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (cnt_d == CW'(MAX_CYC)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid_o[id_q] = 1'b1;
                if (rsp_ready_i[id_q]) begin
                    rr_ptr_d = wrap_add(id_q, 1);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            id_q       <= '0;
            cnt_q      <= '0;
            key_q      <= '0;
            pt_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            key_q      <= key_d;
            pt_q       <= pt_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign core_key_o  = key_q;
    assign core_data_o = pt_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed bench for aes_req_arbiter; the bench itself plays the AES core.
// Inputs change on the falling edge, outputs are checked on the falling edge.
module tb_aes_req_arbiter;

    logic         clk;
    logic         rst_n;
    logic [1:0]   req_valid_i;
    logic [1:0]   req_ready_o;
    logic [255:0] req_key_i;
    logic [255:0] req_data_i;
    logic [1:0]   rsp_valid_o;
    logic [1:0]   rsp_ready_i;
    logic [127:0] rsp_data_o;
    logic         rsp_err_o;
    logic         core_load_o;
    logic [127:0] core_key_o;
    logic [127:0] core_data_o;
    logic [127:0] core_data_i;
    logic         core_done_i;
    logic         busy_o;

    int errors = 0;
    int checks = 0;

    aes_req_arbiter #(.N_REQ(2), .MAX_CYC(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_key_i   (req_key_i),
        .req_data_i  (req_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .core_load_o (core_load_o),
        .core_key_o  (core_key_o),
        .core_data_o (core_data_o),
        .core_data_i (core_data_i),
        .core_done_i (core_done_i),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] AES_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] AES_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] AES_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present a request at an IDLE falling edge and follow it through the LOAD cycle.
    task automatic start_txn(input int k, input logic [127:0] key, input logic [127:0] pt,
                             input bit keep);
        req_valid_i[k] = 1'b1;
        req_key_i[128*k +: 128]  = key;
        req_data_i[128*k +: 128] = pt;
        #1;
        chk("req_ready_grant", 128'(req_ready_o), 128'(2'b01 << k));
        @(negedge clk);
        if (!keep) req_valid_i[k] = 1'b0;
        chk("core_load", 128'(core_load_o), 128'd1);
        chk("core_key", core_key_o, key);
        chk("core_data", core_data_o, pt);
        chk("busy_load", 128'(busy_o), 128'd1);
        chk("req_ready_load", 128'(req_ready_o), 128'd0);
    endtask

    // lat>0: pulse done in the lat-th RUN cycle. lat==0: never pulse, measure the watchdog.
    task automatic run_core(input int lat, input logic [127:0] ct);
        int n;
        if (lat > 0) begin
            repeat (lat) @(negedge clk);
            chk("run_no_rsp", 128'(rsp_valid_o), 128'd0);
            chk("run_load_low", 128'(core_load_o), 128'd0);
            core_done_i = 1'b1;
            core_data_i = ct;
            @(negedge clk);
            core_done_i = 1'b0;
            core_data_i = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        end else begin
            n = 0;
            while (rsp_valid_o == 2'b00 && n < 40) begin
                @(negedge clk);
                n++;
            end
            chk("watchdog_cycles", 128'(n), 128'd17);
        end
    endtask

    task automatic finish_txn(input int k, input logic [127:0] exp_data, input bit exp_err,
                              input int hold);
        logic [1:0] oth;
        oth = ~(2'b01 << k);
        chk("rsp_valid", 128'(rsp_valid_o), 128'(2'b01 << k));
        chk("rsp_data", rsp_data_o, exp_data);
        chk("rsp_err", 128'(rsp_err_o), 128'(exp_err));
        chk("busy_resp", 128'(busy_o), 128'd1);
        for (int h = 0; h < hold; h++) begin
            rsp_ready_i = oth;
            if (h == 0) begin
                core_done_i = 1'b1;
                core_data_i = 128'h55555555_55555555_55555555_55555555;
            end
            @(negedge clk);
            core_done_i = 1'b0;
            chk("hold_valid", 128'(rsp_valid_o), 128'(2'b01 << k));
            chk("hold_data", rsp_data_o, exp_data);
            chk("hold_err", 128'(rsp_err_o), 128'(exp_err));
            chk("hold_no_grant", 128'(req_ready_o), 128'd0);
        end
        rsp_ready_i = 2'b01 << k;
        @(negedge clk);
        rsp_ready_i = 2'b00;
        chk("post_rsp_valid", 128'(rsp_valid_o), 128'd0);
        chk("post_busy", 128'(busy_o), 128'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 128'(req_ready_o), 128'd0);
        chk({tag, "_rsp_valid"}, 128'(rsp_valid_o), 128'd0);
        chk({tag, "_rsp_data"}, rsp_data_o, 128'd0);
        chk({tag, "_rsp_err"}, 128'(rsp_err_o), 128'd0);
        chk({tag, "_core_load"}, 128'(core_load_o), 128'd0);
        chk({tag, "_core_key"}, core_key_o, 128'd0);
        chk({tag, "_core_data"}, core_data_o, 128'd0);
        chk({tag, "_busy"}, 128'(busy_o), 128'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid_i = '0;
        req_key_i   = '0;
        req_data_i  = '0;
        rsp_ready_i = '0;
        core_data_i = '0;
        core_done_i = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single request with the FIPS-197 vector; rr_ptr moves to 1.
        start_txn(0, AES_KEY, AES_PT, 1'b0);
        run_core(10, AES_CT);
        finish_txn(0, AES_CT, 1'b0, 0);

        // Requester 1 with 5 cycles of backpressure, a spurious done in RESP and
        // requester 0 waiting; requester 0 is then granted back-to-back.
        start_txn(1, 128'h11111111_22222222_33333333_44444444,
                  128'ha5a5a5a5_5a5a5a5a_01234567_89abcdef, 1'b0);
        run_core(7, 128'hcafef00d_12345678_9abcdef0_0fedcba9);
        req_valid_i[0] = 1'b1;
        req_key_i[127:0]  = 128'h77777777_77777777_77777777_77777777;
        req_data_i[127:0] = 128'h88888888_88888888_88888888_88888888;
        finish_txn(1, 128'hcafef00d_12345678_9abcdef0_0fedcba9, 1'b0, 5);

        // Watchdog: the core never answers.
        start_txn(0, 128'h77777777_77777777_77777777_77777777,
                  128'h88888888_88888888_88888888_88888888, 1'b0);
        run_core(0, '0);
        finish_txn(0, 128'd0, 1'b1, 0);

        // Done arrives in the 16th RUN cycle, together with the watchdog: done wins.
        start_txn(1, 128'h0badc0de_0badc0de_0badc0de_0badc0de,
                  128'h13579bdf_2468ace0_13579bdf_2468ace0, 1'b0);
        run_core(16, 128'hfeedface_feedface_feedface_feedface);
        finish_txn(1, 128'hfeedface_feedface_feedface_feedface, 1'b0, 0);

        // Spurious done while IDLE.
        core_done_i = 1'b1;
        core_data_i = 128'h99999999_99999999_99999999_99999999;
        @(negedge clk);
        core_done_i = 1'b0;
        chk("idle_spurious_busy", 128'(busy_o), 128'd0);
        chk("idle_spurious_load", 128'(core_load_o), 128'd0);
        chk("idle_spurious_valid", 128'(rsp_valid_o), 128'd0);
        chk("idle_spurious_data", rsp_data_o, 128'hfeedface_feedface_feedface_feedface);

        // Both requesters held valid: grant order 0,1,0,1.
        req_valid_i = 2'b11;
        req_key_i   = {128'hbbbbbbbb_00000001_bbbbbbbb_00000001,
                       128'haaaaaaaa_00000000_aaaaaaaa_00000000};
        req_data_i  = {128'hdddddddd_11111111_dddddddd_11111111,
                       128'hcccccccc_00000000_cccccccc_00000000};
        for (int j = 0; j < 4; j++) begin
            start_txn(j % 2, req_key_i[128*(j%2) +: 128], req_data_i[128*(j%2) +: 128], 1'b1);
            run_core(2 + j, 128'h0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f00 + 128'(j));
            finish_txn(j % 2, 128'h0f0f0f0f_0f0f0f0f_0f0f0f0f_0f0f0f00 + 128'(j), 1'b0, 0);
        end
        req_valid_i = 2'b00;

        // Leave rr_ptr at 1, then reset in the middle of a requester-1 RUN.
        start_txn(0, 128'h2222_3333_4444_5555_6666_7777_8888_9999,
                  128'h1234_1234_1234_1234_1234_1234_1234_1234, 1'b0);
        run_core(4, 128'h5a5a_5a5a_5a5a_5a5a_5a5a_5a5a_5a5a_5a5a);
        finish_txn(0, 128'h5a5a_5a5a_5a5a_5a5a_5a5a_5a5a_5a5a_5a5a, 1'b0, 0);
        start_txn(1, 128'h9999_8888_7777_6666_5555_4444_3333_2222,
                  128'h4321_4321_4321_4321_4321_4321_4321_4321, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req_valid_i = 2'b11;
        req_key_i   = {128'h10101010_10101010_10101010_10101010,
                       128'h01010101_01010101_01010101_01010101};
        req_data_i  = {128'h20202020_20202020_20202020_20202020,
                       128'h02020202_02020202_02020202_02020202};
        start_txn(0, 128'h01010101_01010101_01010101_01010101,
                  128'h02020202_02020202_02020202_02020202, 1'b0);
        req_valid_i[1] = 1'b0;
        run_core(3, 128'h3c3c3c3c_3c3c3c3c_3c3c3c3c_3c3c3c3c);
        finish_txn(0, 128'h3c3c3c3c_3c3c3c3c_3c3c3c3c_3c3c3c3c, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
